// File: rtl/park_pkg.sv
// Shared types and default constants for the sequential inverse Park transform.
// Operand width and sin/cos fractional precision defaults live here.
package park_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int Q_BITS_DEF  = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        DONE = 3'd5
    } park_state_e;

    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_LOAD = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_SUB  = 2'd3
    } mac_op_e;

endpackage : park_pkg

// File: rtl/inverse_park_seq_if.sv
// Operand/result handshake bundle of inverse_park_seq.
// The slave modport is the transform block and the master modport is its user.
interface inverse_park_seq_if #(
    parameter int D_WIDTH = 32
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic signed [D_WIDTH-1:0] d;
    logic signed [D_WIDTH-1:0] q;
    logic signed [D_WIDTH-1:0] sin;
    logic signed [D_WIDTH-1:0] cos;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      busy;

    modport slave (
        input  in_valid, d, q, sin, cos, out_ready,
        output in_ready, out_valid, alpha, beta, busy
    );

    modport master (
        output in_valid, d, q, sin, cos, out_ready,
        input  in_ready, out_valid, alpha, beta, busy
    );

endinterface : inverse_park_seq_if

// File: rtl/park_mac.sv
// Single shared signed multiplier with a 2*D_WIDTH+1 bit accumulator.
// LOAD stores the product; ADD/SUB present acc +/- product on sum_o.
module park_mac
    import park_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  mac_op_e                     op_i,
    input  logic signed [D_WIDTH-1:0]   a_i,
    input  logic signed [D_WIDTH-1:0]   b_i,
    output logic signed [2*D_WIDTH:0]   sum_o
);

    logic signed [2*D_WIDTH-1:0] prod_s;
    logic signed [2*D_WIDTH:0]   prod_x_s;
    logic signed [2*D_WIDTH:0]   acc_q;
    logic signed [2*D_WIDTH:0]   acc_d;

    assign prod_s   = a_i * b_i;
    assign prod_x_s = {prod_s[2*D_WIDTH-1], prod_s};

    always_comb begin
        acc_d = acc_q;
        sum_o = acc_q;
        case (op_i)
            MAC_LOAD: begin
                acc_d = prod_x_s;
                sum_o = prod_x_s;
            end
            MAC_ADD:  sum_o = acc_q + prod_x_s;
            MAC_SUB:  sum_o = acc_q - prod_x_s;
            MAC_HOLD: sum_o = acc_q;
            default:  sum_o = acc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : park_mac

// File: rtl/inverse_park_seq.sv
// Sequential inverse Park transform: alpha = (d*cos - q*sin) >>> Q_BITS, beta = (d*sin + q*cos) >>> Q_BITS.
// Define PARK_SAT_EN to saturate results; by default they wrap to D_WIDTH bits.
module inverse_park_seq
    import park_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int Q_BITS  = Q_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    inverse_park_seq_if.slave   bus
);

`ifdef PARK_SAT_EN
    localparam logic signed [2*D_WIDTH:0] SAT_MAX = {{(D_WIDTH+2){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [2*D_WIDTH:0] SAT_MIN = {{(D_WIDTH+2){1'b1}}, {(D_WIDTH-1){1'b0}}};
`endif

    park_state_e               state_q;
    park_state_e               state_d;
    logic signed [D_WIDTH-1:0] d_q;
    logic signed [D_WIDTH-1:0] q_q;
    logic signed [D_WIDTH-1:0] sin_q;
    logic signed [D_WIDTH-1:0] cos_q;
    logic signed [D_WIDTH-1:0] alpha_q;
    logic signed [D_WIDTH-1:0] beta_q;
    logic                      out_valid_q;
    logic                      busy_q;
    logic                      in_ready_q;
    logic                      accept_s;

    mac_op_e                   mac_op_s;
    logic signed [D_WIDTH-1:0] mac_a_s;
    logic signed [D_WIDTH-1:0] mac_b_s;
    logic signed [2*D_WIDTH:0] mac_sum_s;

    // Shift at full accumulator width first so no product bits are lost before narrowing.
    function automatic logic signed [D_WIDTH-1:0] narrow(input logic signed [2*D_WIDTH:0] v);
        logic signed [2*D_WIDTH:0] s;
        s = v >>> Q_BITS;
`ifdef PARK_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[D_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[D_WIDTH-1:0];
        end else begin
            return s[D_WIDTH-1:0];
        end
`else
        return s[D_WIDTH-1:0];
`endif
    endfunction

    assign accept_s = bus.in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = M0;
                end else begin
                    state_d = IDLE;
                end
            end
            M0:   state_d = M1;
            M1:   state_d = M2;
            M2:   state_d = M3;
            M3:   state_d = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One product per cycle: d*cos, q*sin, d*sin, q*cos.
    always_comb begin
        mac_op_s = MAC_HOLD;
        mac_a_s  = '0;
        mac_b_s  = '0;
        case (state_q)
            M0: begin
                mac_op_s = MAC_LOAD;
                mac_a_s  = d_q;
                mac_b_s  = cos_q;
            end
            M1: begin
                mac_op_s = MAC_SUB;
                mac_a_s  = q_q;
                mac_b_s  = sin_q;
            end
            M2: begin
                mac_op_s = MAC_LOAD;
                mac_a_s  = d_q;
                mac_b_s  = sin_q;
            end
            M3: begin
                mac_op_s = MAC_ADD;
                mac_a_s  = q_q;
                mac_b_s  = cos_q;
            end
            default: begin
                mac_op_s = MAC_HOLD;
                mac_a_s  = '0;
                mac_b_s  = '0;
            end
        endcase
    end

    park_mac #(
        .D_WIDTH (D_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .op_i  (mac_op_s),
        .a_i   (mac_a_s),
        .b_i   (mac_b_s),
        .sum_o (mac_sum_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q   <= '0;
            q_q   <= '0;
            sin_q <= '0;
            cos_q <= '0;
        end else if (accept_s) begin
            d_q   <= bus.d;
            q_q   <= bus.q;
            sin_q <= bus.sin;
            cos_q <= bus.cos;
        end else begin
            d_q   <= d_q;
            q_q   <= q_q;
            sin_q <= sin_q;
            cos_q <= cos_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alpha_q <= '0;
            beta_q  <= '0;
        end else if (state_q == M1) begin
            alpha_q <= narrow(mac_sum_s);
        end else if (state_q == M3) begin
            beta_q  <= narrow(mac_sum_s);
        end else begin
            alpha_q <= alpha_q;
            beta_q  <= beta_q;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alpha     = alpha_q;
    assign bus.beta      = beta_q;

endmodule : inverse_park_seq

// File: tb/tb_inverse_park_seq.sv
// Directed self-checking bench for inverse_park_seq (D_WIDTH=32, Q_BITS=10).
// Expected values are hand-computed; PARK_SAT_EN selects the saturating expectation.
module tb_inverse_park_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    inverse_park_seq_if #(.D_WIDTH(32)) bus ();

    inverse_park_seq #(
        .D_WIDTH (32),
        .Q_BITS  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] dv, input logic [31:0] qv,
                         input logic [31:0] sv, input logic [31:0] cv);
        bus.d   = dv;
        bus.q   = qv;
        bus.sin = sv;
        bus.cos = cv;
    endtask

    // Steps until out_valid or the budget expires; lat counts steps taken.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] dv, input logic [31:0] qv,
                        input logic [31:0] sv, input logic [31:0] cv,
                        input logic [31:0] ea, input logic [31:0] eb);
        int lat;
        chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        drive(dv, qv, sv, cv);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom);
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        wait_valid(lat);
        chk({tag, " latency"}, 32'(lat + 1), 32'd5);
        chk({tag, " alpha"}, bus.alpha, ea);
        chk({tag, " beta"}, bus.beta, eb);
        step();
        chk({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    logic [31:0] va_d [4];
    logic [31:0] va_q [4];
    logic [31:0] va_s [4];
    logic [31:0] va_c [4];
    logic [31:0] va_a [4];
    logic [31:0] va_b [4];

    initial begin
        int lat;
        int cyc;
        int last;
        int k_in;
        int k_out;
        logic [31:0] exp29;

        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset alpha", bus.alpha, 32'd0);
        chk("reset beta", bus.beta, 32'd0);
        rst = 1'b0;
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();

        xfer("unit d", 32'd1024, 32'd0, 32'd0, 32'd1024, 32'd1024, 32'd0);
        xfer("unit q", 32'd0, 32'd2048, 32'd1024, 32'd0, -32'sd2048, 32'd0);
        xfer("45deg", 32'd512, 32'd512, 32'd724, 32'd724, 32'd0, 32'd724);
        xfer("asr floor", -32'sd1, 32'd0, 32'd0, 32'd1, -32'sd1, 32'd0);
`ifdef PARK_SAT_EN
        exp29 = 32'h7FFF_FFFF;
`else
        exp29 = 32'hFFFF_FFFF;
`endif
        xfer("overflow", 32'h7FFF_FFFF, 32'h8000_0000, 32'd1024, 32'd1024, exp29, 32'hFFFF_FFFF);

        // Reset in M2: alpha already holds 1024, beta still holds -1.
        drive(32'd1024, 32'd0, 32'd0, 32'd1024);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("rst pre busy", {31'd0, bus.busy}, 32'd1);
        chk("rst pre alpha", bus.alpha, 32'd1024);
        rst = 1'b1;
        #1;
        chk("rst async alpha", bus.alpha, 32'd0);
        chk("rst async beta", bus.beta, 32'd0);
        chk("rst async busy", {31'd0, bus.busy}, 32'd0);
        chk("rst async out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        rst = 1'b0;
        chk("rst release in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rst no output", {31'd0, bus.out_valid}, 32'd0);
        end

        // Consumer stall in DONE with new operands already offered.
        bus.out_ready = 1'b0;
        drive(32'd512, 32'd512, 32'd724, 32'd724);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("stall latency", 32'(lat + 1), 32'd5);
        drive(32'd1024, 32'd0, 32'd0, 32'd1024);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall alpha", bus.alpha, 32'd0);
            chk("stall beta", bus.beta, 32'd724);
            chk("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("stall release out_valid", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("stall idle in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("stall idle out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("stall next accepted", {31'd0, bus.busy}, 32'd1);
        chk("stall next in_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_valid(lat);
        chk("stall next latency", 32'(lat + 1), 32'd5);
        chk("stall next alpha", bus.alpha, 32'd1024);
        chk("stall next beta", bus.beta, 32'd0);
        step();

        // Back-to-back with in_valid held high and operands scrambled outside IDLE.
        va_d[0] = 32'd1024;   va_q[0] = 32'd0;    va_s[0] = 32'd0;    va_c[0] = 32'd1024;
        va_a[0] = 32'd1024;   va_b[0] = 32'd0;
        va_d[1] = 32'd0;      va_q[1] = 32'd2048; va_s[1] = 32'd1024; va_c[1] = 32'd0;
        va_a[1] = -32'sd2048; va_b[1] = 32'd0;
        va_d[2] = 32'd512;    va_q[2] = 32'd512;  va_s[2] = 32'd724;  va_c[2] = 32'd724;
        va_a[2] = 32'd0;      va_b[2] = 32'd724;
        va_d[3] = -32'sd3000; va_q[3] = 32'd1000; va_s[3] = 32'd0;    va_c[3] = 32'd1024;
        va_a[3] = -32'sd3000; va_b[3] = 32'd1000;
        bus.in_valid = 1'b1;
        k_in  = 0;
        k_out = 0;
        cyc   = 0;
        last  = -1;
        while (k_out < 4 && cyc < 60) begin
            if (bus.in_ready && k_in < 4) begin
                drive(va_d[k_in], va_q[k_in], va_s[k_in], va_c[k_in]);
                k_in++;
            end else begin
                drive($urandom, $urandom, $urandom, $urandom);
            end
            if (bus.out_valid) begin
                chk("b2b alpha", bus.alpha, va_a[k_out]);
                chk("b2b beta", bus.beta, va_b[k_out]);
                if (last >= 0) begin
                    chk("b2b spacing", 32'(cyc - last), 32'd6);
                end
                last = cyc;
                k_out++;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("b2b result count", 32'(k_out), 32'd4);
        chk("b2b end in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inverse_park_seq

// File: doc/inverse_park_seq.md
INVERSE_PARK_SEQ -- requirements
Module: inverse_park_seq

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, signed data width of all operands and results.
REQ-002 SHALL have parameter Q_BITS, default 10, fractional bits of sin/cos (1.0 = 2^Q_BITS).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand set d/q/sin/cos valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operand set.
REQ-007 SHALL have ports d, q, sin, cos  input  D_WIDTH each  signed operands.
REQ-008 SHALL have port out_valid  output  1  alpha/beta valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports alpha, beta  output  D_WIDTH each  signed results.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL compute alpha = (d*cos - q*sin) >>> Q_BITS and beta = (d*sin + q*cos) >>> Q_BITS, using one shared signed multiplier.
REQ-013 SHALL use FSM states IDLE, M0, M1, M2, M3, DONE.
REQ-014 SHALL drive in_ready high only in IDLE; input handshake = in_valid & in_ready latches d/q/sin/cos and moves IDLE->M0.
REQ-015 SHALL perform, one product per cycle: M0 acc=d*cos; M1 alpha_reg=acc-q*sin; M2 acc=d*sin; M3 beta_reg=acc+q*cos; then M0->M1->M2->M3->DONE unconditionally.
REQ-016 SHALL hold products at 2*D_WIDTH bits and the accumulator at 2*D_WIDTH+1 bits; apply the arithmetic shift to the full-width sum before narrowing.
REQ-017 SHALL assert out_valid only in DONE; handshake at T gives out_valid at T+5.
REQ-018 SHALL hold alpha/beta stable while out_valid & !out_ready; DONE->IDLE on out_valid & out_ready.
REQ-019 SHALL ignore operand changes after the input handshake; in_valid in any non-IDLE state has no effect.
REQ-020 SHALL sustain a minimum of 6 cycles per transform (no overlap).

Reset
REQ-021 SHALL on rst, at any state, go to IDLE immediately and clear alpha, beta, out_valid, busy, acc and operand registers to 0.
REQ-022 SHALL drive in_ready high in the first cycle after rst deasserts; an interrupted transform produces no output.

Configuration
REQ-023 SHALL, with PARK_SAT_EN defined, saturate each shifted result to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
REQ-024 SHALL, without PARK_SAT_EN, narrow by taking the low D_WIDTH bits (two's-complement wrap); timing and handshake identical in both builds.

Structure
REQ-025 SHALL place the FSM state enum and the default D_WIDTH/Q_BITS constants in shared package park_pkg.
REQ-026 SHALL implement the multiplier and accumulator, with load/add/sub control, in sub-module park_mac; inverse_park_seq holds the FSM, operand registers and output narrowing.

Verification
REQ-027 SHALL cover: d=1024, q=0, cos=1024, sin=0 -> alpha=1024, beta=0, out_valid 5 cycles after handshake.
REQ-028 SHALL cover: d=0, q=2048, sin=1024, cos=0 -> alpha=-2048, beta=0; and d=512, q=512, sin=cos=724 -> alpha=0, beta=724.
REQ-029 SHALL cover: d=32'h7FFFFFFF, q=-2^31, sin=cos=1024 -> alpha=32'h7FFFFFFF with PARK_SAT_EN, 32'hFFFFFFFF without; beta=-1 in both.
REQ-030 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid and alpha/beta stable, in_ready low; next handshake accepted 1 cycle after out_ready rises.
REQ-031 SHALL cover: rst pulsed during M2 -> all outputs 0 immediately, no out_valid for that transform, in_ready high the cycle after release.
REQ-032 SHALL cover: in_valid held high continuously with out_ready=1 -> one result every 6 cycles, operands sampled only in IDLE.
